q2_alu_buttons: RTL and testbench
=================================

// Module: q2_alu_buttons
// PURPOSE
//  Bit-serial ALU datapath cell plus debounced front-panel button port for the Q2 CPU.
//  - The ALU computes one result bit per step from the LSBs of A and X.
//    Its carry/flag is held externally in the F slice.
//  - The button port debounces raw switches on clk.
//    It places them on the shared open-drain 12-bit data bus during an I/O read.
//  - Bus pull-down uses the same semantics as the nfet primitive:
//    drive 0 when enabled, high-Z otherwise; the external pull-up supplies 1.
// PARAMETERS
//  NBTN      4   number of buttons, mapped to dbus[NBTN-1:0]; 1..12
//  DEBOUNCE  16  consecutive stable clk samples required to accept a change; >=2
// PORTS
//  clk      in     1     system clock, rising edge
//  rst      in     1     reset: asynchronous, active-high
//  a0       in     1     A register LSB (current serial bit)
//  x0       in     1     X register LSB
//  x1       in     1     X register bit 1 (used by shift op)
//  f        in     1     stored carry/flag bit (carry-in)
//  o0       in     1     opcode bit 0
//  o1       in     1     opcode bit 1
//  alu_out  out    1     result bit, shifted into A[11]
//  alu_cout out    1     carry-out, captured into F
//  btn      in     NBTN  raw button inputs, 1 = pressed, asynchronous
//  rd       in     1     I/O read strobe, active-high
//  dbus     inout  12    open-drain data bus; only 0 or z is ever driven
// BEHAVIOUR
//  ALU (purely combinational, no clk dependence, unaffected by rst):
//   {o1,o0}=00 ADD:  alu_out = a0^x0^f; alu_cout = maj(a0,x0,f)
//   {o1,o0}=01 NOR:  alu_out = ~(a0|x0); alu_cout = f
//   {o1,o0}=10 LOAD: alu_out = x0;       alu_cout = f
//   {o1,o0}=11 LSR:  alu_out = x1;       alu_cout = x0 (bit shifted out)
//   No X/Z on outputs when all inputs are known.
//  Buttons:
//   - Two-flop synchronizer on each btn bit, then a per-button counter.
//   - Debounced state db[i] toggles when the synchronized bit differs from db[i]
//     for DEBOUNCE consecutive clk edges.
//   - Any sample equal to db[i] clears that button's counter.
//   - Latency from a clean input edge to db[i] change is DEBOUNCE+2 cycles.
//   - Glitches shorter than DEBOUNCE cycles are ignored.
//   - The counter saturates and never wraps.
//   - rst (async, active-high) clears db, the counters and the synchronizers.
//     db = all released.
//  Bus drive:
//   - dbus[i] = 0 when rd & db[i]; z otherwise (i < NBTN).
//   - dbus[NBTN..11] are always z.
//   - The drive is combinational from rd; it goes z immediately when rd falls.
//   - With rd=0 or during rst, every dbus bit is z.
//   - rd held high across a db change: the bus follows db in the same cycle.
// TESTING
//  - ALU ADD, a0=1 x0=1 f=1 -> alu_out=1, alu_cout=1.
//    a0=1 x0=0 f=0 -> alu_out=1, alu_cout=0.
//  - ALU sweep over all 64 input combinations vs the table above.
//    NOR a0=0 x0=0 -> 1; LSR x1=1 x0=0 -> alu_out=1, alu_cout=0.
//  - btn[0] rises and holds -> db[0]=1 after DEBOUNCE+2 clks.
//    With rd=1, dbus[0]=0 and dbus[11:1]=z.
//  - btn[1] pulse of DEBOUNCE-1 clks -> db[1] stays 0; dbus[1] stays z under rd=1.
//  - Assert rst mid-count and while db[2]=1 -> db clears asynchronously.
//    dbus is all z; after release, a re-press needs the full DEBOUNCE+2 again.
//  - rd=0 with all buttons pressed and debounced -> dbus=12'bz.
//    rd rising -> low bits 0 with no clk edge needed.

Source files
------------

// File: rtl/q2_alu_buttons.sv
// q2_alu_buttons
//   Bit-serial ALU cell and debounced front-panel button port for the Q2 CPU.
//   The ALU produces one result bit per step from the LSBs of A and X. The
//   carry/flag is stored outside this cell, in the F slice. The button port
//   debounces the raw switches and pulls the shared open-drain data bus low
//   during an I/O read.
//
// Ports
//   clk      in     system clock, rising edge
//   rst      in     asynchronous, active-high reset (button logic only)
//   a0       in     A register LSB
//   x0       in     X register LSB
//   x1       in     X register bit 1 (shift source)
//   f        in     stored carry/flag (carry-in)
//   o0, o1   in     opcode {o1,o0}: 00 ADD, 01 NOR, 10 LOAD, 11 LSR
//   alu_out  out    result bit, shifted into A[11]
//   alu_cout out    carry-out, captured into F
//   btn      in     raw buttons, 1 = pressed, asynchronous to clk
//   rd       in     I/O read strobe, active-high
//   dbus     inout  12-bit open-drain bus; only 0 or z is ever driven
module q2_alu_buttons #(
    parameter int NBTN     = 4,
    parameter int DEBOUNCE = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            a0,
    input  logic            x0,
    input  logic            x1,
    input  logic            f,
    input  logic            o0,
    input  logic            o1,
    output logic            alu_out,
    output logic            alu_cout,
    input  logic [NBTN-1:0] btn,
    input  logic            rd,
    inout  wire  [11:0]     dbus
);

    localparam int CW = (DEBOUNCE > 2) ? $clog2(DEBOUNCE) : 1;
    localparam logic [CW-1:0] CNT_RELOAD = CW'(DEBOUNCE - 1);

    // ------------------------------------------------------------------
    // ALU: purely combinational; it does not depend on clk or rst.
    // ------------------------------------------------------------------
    always_comb begin
        alu_out  = 1'b0;
        alu_cout = f;
        unique case ({o1, o0})
            2'b00: begin
                alu_out  = a0 ^ x0 ^ f;
                alu_cout = (a0 & x0) | (a0 & f) | (x0 & f);
            end
            2'b01: alu_out = ~(a0 | x0);
            2'b10: alu_out = x0;
            2'b11: begin
                alu_out  = x1;
                alu_cout = x0;
            end
            default: alu_out = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Button debounce
    // The counter for each button counts down from DEBOUNCE-1 while the
    // synchronized sample differs from the debounced state. The state
    // toggles on the edge that sees the counter at zero, which is the
    // DEBOUNCE-th consecutive differing sample. Any agreeing sample
    // reloads the counter. Because the counter is reloaded at terminal
    // count, it can never wrap.
    // ------------------------------------------------------------------
    logic [NBTN-1:0] sync1_q, sync2_q;
    logic [NBTN-1:0] db_q, db_d;
    logic [CW-1:0]   cnt_q [NBTN];
    logic [CW-1:0]   cnt_d [NBTN];

    always_comb begin
        for (int i = 0; i < NBTN; i++) begin
            db_d[i]  = db_q[i];
            cnt_d[i] = CNT_RELOAD;
            if (sync2_q[i] != db_q[i]) begin
                if (cnt_q[i] == '0) begin
                    db_d[i] = ~db_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            db_q    <= '0;
            for (int i = 0; i < NBTN; i++) begin
                cnt_q[i] <= CNT_RELOAD;
            end
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            for (int i = 0; i < NBTN; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Open-drain bus: pull low only for a pressed button during a read.
    // The drive is combinational from rd, so the bus releases at once
    // when rd falls. Reset clears db_q asynchronously, which also
    // releases the bus during reset.
    // ------------------------------------------------------------------
    for (genvar g = 0; g < 12; g++) begin : g_bus
        if (g < NBTN) begin : g_drv
            assign dbus[g] = (rd && db_q[g]) ? 1'b0 : 1'bz;
        end else begin : g_idle
            assign dbus[g] = 1'bz;
        end
    end

endmodule

// File: tb/tb_q2_alu_buttons.sv
module tb_q2_alu_buttons;

    localparam int NBTN     = 4;
    localparam int DEBOUNCE = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic            a0, x0, x1, f, o0, o1;
    logic            alu_out, alu_cout;
    logic [NBTN-1:0] btn;
    logic            rd;
    wire  [11:0]     dbus;

    // The external pull-up turns a released (z) bus bit into 1.
    for (genvar g = 0; g < 12; g++) begin : g_pu
        pullup (dbus[g]);
    end

    q2_alu_buttons #(.NBTN(NBTN), .DEBOUNCE(DEBOUNCE)) dut (
        .clk(clk), .rst(rst),
        .a0(a0), .x0(x0), .x1(x1), .f(f), .o0(o0), .o1(o1),
        .alu_out(alu_out), .alu_cout(alu_cout),
        .btn(btn), .rd(rd), .dbus(dbus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      name;
        logic [1:0] op;
        logic       a0, x0, x1, f;
        logic       exp_out, exp_cout;
    } alu_vec_t;

    typedef struct {
        string      name;
        logic [1:0] exp;
    } alu_exp_t;

    typedef struct {
        string       name;
        logic [11:0] exp;
    } bus_exp_t;

    alu_exp_t alu_q[$];
    bus_exp_t bus_q[$];

    // Reference ALU model. ADD is computed as an arithmetic sum.
    function automatic logic [1:0] alu_model(logic [1:0] op, logic a, logic x,
                                             logic xh, logic c);
        logic [1:0] s;
        s = {1'b0, a} + {1'b0, x} + {1'b0, c};
        case (op)
            2'd0:    return {s[0], s[1]};
            2'd1:    return {!(a || x), c};
            2'd2:    return {x, c};
            default: return {xh, x};
        endcase
    endfunction

    task automatic expect_bus(input string name, input logic [11:0] exp);
        bus_exp_t e;
        e.name = name;
        e.exp  = exp;
        bus_q.push_back(e);
    endtask

    task automatic check_bus();
        bus_exp_t e;
        e = bus_q.pop_front();
        checks++;
        if (dbus !== e.exp) begin
            errors++;
            $display("FAIL %s: dbus got %03h expected %03h", e.name, dbus, e.exp);
        end
    endtask

    task automatic bus_step(input string name, input logic [11:0] exp);
        expect_bus(name, exp);
        #1;
        check_bus();
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    alu_vec_t vecs[$];

    initial begin
        alu_vec_t v;
        alu_exp_t e;
        logic [1:0] m;

        rst = 1'b1; btn = '0; rd = 1'b1;
        a0 = 0; x0 = 0; x1 = 0; f = 0; o0 = 0; o1 = 0;

        // ---------------- ALU vectors ----------------
        vecs.push_back('{"add_111", 2'd0, 1, 1, 0, 1, 1'b1, 1'b1});
        vecs.push_back('{"add_100", 2'd0, 1, 0, 0, 0, 1'b1, 1'b0});
        vecs.push_back('{"nor_00",  2'd1, 0, 0, 0, 0, 1'b1, 1'b0});
        vecs.push_back('{"lsr_x1",  2'd3, 0, 0, 1, 0, 1'b1, 1'b0});
        for (int i = 0; i < 64; i++) begin
            logic [5:0] b;
            b = 6'(i);
            v.name = $sformatf("sweep_%0d", i);
            v.op = b[5:4]; v.x1 = b[3]; v.x0 = b[2]; v.a0 = b[1]; v.f = b[0];
            m = alu_model(v.op, v.a0, v.x0, v.x1, v.f);
            v.exp_out = m[1]; v.exp_cout = m[0];
            vecs.push_back(v);
        end

        // ALU is exercised while rst is high: it must not depend on reset.
        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            {o1, o0} = v.op; a0 = v.a0; x0 = v.x0; x1 = v.x1; f = v.f;
            e.name = v.name;
            e.exp  = {v.exp_out, v.exp_cout};
            alu_q.push_back(e);
            #1;
            e = alu_q.pop_front();
            checks++;
            if ({alu_out, alu_cout} !== e.exp) begin
                errors++;
                $display("FAIL %s: {out,cout} got %b expected %b", e.name,
                         {alu_out, alu_cout}, e.exp);
            end
        end

        // ---------------- buttons ----------------
        bus_step("reset_bus", 12'hFFF);
        edges(2);
        rst = 1'b0;
        edges(2);
        bus_step("idle_bus", 12'hFFF);

        // btn[0] press: db changes on the DEBOUNCE+2-th edge.
        btn = 4'b0001;
        edges(DEBOUNCE + 1);
        bus_step("press0_early", 12'hFFF);
        edges(1);
        bus_step("press0_db", 12'hFFE);
        rd = 1'b0;
        bus_step("press0_rd0", 12'hFFF);
        rd = 1'b1;
        bus_step("press0_rd1", 12'hFFE);

        // btn[1] glitch of DEBOUNCE-1 cycles is ignored.
        btn = 4'b0011;
        for (int i = 0; i < DEBOUNCE - 1; i++) begin
            edges(1);
            bus_step($sformatf("glitch1_hi_%0d", i), 12'hFFE);
        end
        btn = 4'b0001;
        for (int i = 0; i < DEBOUNCE + 4; i++) begin
            edges(1);
            bus_step($sformatf("glitch1_lo_%0d", i), 12'hFFE);
        end

        // btn[2] debounced, then reset asserted mid-count of btn[3].
        btn = 4'b0101;
        edges(DEBOUNCE + 2);
        bus_step("press2_db", 12'hFFA);
        btn = 4'b1101;
        edges(8);
        bus_step("press3_midcount", 12'hFFA);
        #2;
        rst = 1'b1;
        bus_step("rst_async_clear", 12'hFFF);
        edges(2);
        bus_step("rst_held", 12'hFFF);
        rst = 1'b0;
        edges(DEBOUNCE + 1);
        bus_step("repress_early", 12'hFFF);
        edges(1);
        bus_step("repress_db", 12'hFF2);

        // All buttons pressed: rd alone gates the bus, with no clock edge.
        btn = 4'b1111;
        edges(DEBOUNCE + 2);
        bus_step("all_db", 12'hFF0);
        rd = 1'b0;
        bus_step("all_rd0", 12'hFFF);
        #2;
        rd = 1'b1;
        bus_step("all_rd_rise", 12'hFF0);

        // Release: db follows with the same latency while rd is held.
        btn = 4'b0000;
        edges(DEBOUNCE + 1);
        bus_step("release_early", 12'hFF0);
        edges(1);
        bus_step("release_db", 12'hFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: sim time %0t limit 200000", $time);
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
